// File: rtl/tt_scan_ctrl.sv
// Scan-chain sequencer: shifts a latched pattern MSB-first into a target chain while capturing its old contents.
// Optional macro TT_SCAN_CTRL_VERIFY_EN adds a second read-back burst and the o_verify_err flag.
module tt_scan_ctrl #(
   parameter int CHAIN_LEN = 4,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [CHAIN_LEN-1:0] i_load_data,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [CHAIN_LEN-1:0] o_capture_data,
   output logic                 o_scan_en,
   output logic                 o_scan_in,
   input  logic                 i_scan_out,
   output logic                 o_verify_err
);

   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(CHAIN_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
`ifdef TT_SCAN_CTRL_VERIFY_EN
      ST_VERIFY,
`endif
      ST_DONE
   } state_t;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [CHAIN_LEN-1:0]   shift_reg;
   logic [CHAIN_LEN-2:0]   cap_reg;
   logic [CHAIN_LEN-1:0]   cap_full;
   logic                   last_bit;
   logic                   busy_next, done_next, scan_en_next, scan_in_next;

   // cap_full includes the bit being sampled on the current edge
   assign cap_full = {cap_reg, i_scan_out};
   assign last_bit = (cnt_reg == LAST_K);

`ifdef TT_SCAN_CTRL_VERIFY_EN
   logic [CHAIN_LEN-1:0] load_reg;
   logic [CHAIN_LEN-1:0] first_cap_reg;
   logic [CHAIN_LEN-1:0] bit_diff;

   for (genvar gi = 0; gi < CHAIN_LEN; gi++) begin : g_diff
      assign bit_diff[gi] = cap_full[gi] ^ load_reg[gi];
   end
`else
   assign o_verify_err = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE:  if (i_start) state_next = ST_SHIFT;
`ifdef TT_SCAN_CTRL_VERIFY_EN
         ST_SHIFT:  if (last_bit) state_next = ST_VERIFY;
         ST_VERIFY: if (last_bit) state_next = ST_DONE;
`else
         ST_SHIFT:  if (last_bit) state_next = ST_DONE;
`endif
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Output comb: next values of the registered pins, derived from the coming state
   always_comb begin
      busy_next    = (state_next != ST_IDLE);
      done_next    = (state_next == ST_DONE);
`ifdef TT_SCAN_CTRL_VERIFY_EN
      scan_en_next = (state_next == ST_SHIFT) || (state_next == ST_VERIFY);
`else
      scan_en_next = (state_next == ST_SHIFT);
`endif
      scan_in_next = 1'b0;
      cnt_next     = '0;
      unique case (state_reg)
         ST_IDLE: begin
            if (i_start) scan_in_next = i_load_data[CHAIN_LEN-1];
         end
         ST_SHIFT: begin
            if (!last_bit) begin
               scan_in_next = shift_reg[CHAIN_LEN-2];
               cnt_next     = cnt_reg + 1'b1;
            end
`ifdef TT_SCAN_CTRL_VERIFY_EN
            else begin
               scan_in_next = load_reg[CHAIN_LEN-1];
            end
`endif
         end
`ifdef TT_SCAN_CTRL_VERIFY_EN
         ST_VERIFY: begin
            if (!last_bit) begin
               scan_in_next = shift_reg[CHAIN_LEN-2];
               cnt_next     = cnt_reg + 1'b1;
            end
         end
`endif
         default: begin
            scan_in_next = 1'b0;
            cnt_next     = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_reg        <= '0;
         shift_reg      <= '0;
         cap_reg        <= '0;
         o_busy         <= 1'b0;
         o_done         <= 1'b0;
         o_scan_en      <= 1'b0;
         o_scan_in      <= 1'b0;
         o_capture_data <= '0;
`ifdef TT_SCAN_CTRL_VERIFY_EN
         load_reg       <= '0;
         first_cap_reg  <= '0;
         o_verify_err   <= 1'b0;
`endif
      end else begin
         cnt_reg   <= cnt_next;
         o_busy    <= busy_next;
         o_done    <= done_next;
         o_scan_en <= scan_en_next;
         o_scan_in <= scan_in_next;
         unique case (state_reg)
            ST_IDLE: begin
               if (i_start) begin
                  shift_reg <= i_load_data;
`ifdef TT_SCAN_CTRL_VERIFY_EN
                  load_reg     <= i_load_data;
                  o_verify_err <= 1'b0;
`endif
               end
            end
            ST_SHIFT: begin
               cap_reg   <= cap_full[CHAIN_LEN-2:0];
               shift_reg <= shift_reg << 1;
               if (last_bit) begin
`ifdef TT_SCAN_CTRL_VERIFY_EN
                  first_cap_reg <= cap_full;
                  shift_reg     <= load_reg;
`else
                  o_capture_data <= cap_full;
`endif
               end
            end
`ifdef TT_SCAN_CTRL_VERIFY_EN
            ST_VERIFY: begin
               cap_reg   <= cap_full[CHAIN_LEN-2:0];
               shift_reg <= shift_reg << 1;
               if (last_bit) begin
                  o_capture_data <= first_cap_reg;
                  o_verify_err   <= |bit_diff;
               end
            end
`endif
            default: begin
               cap_reg <= cap_reg;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Self-checking bench for tt_scan_ctrl: drives bursts into a behavioural target shift register
// and checks scan sequence, latency, capture and final chain contents against the expected values.
module tb_tt_scan_ctrl;

   localparam int N = 4;
`ifdef TT_SCAN_CTRL_VERIFY_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif
   // counting the start cycle as cycle 1
   localparam int LAT = PASSES * N + 2;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_start = 1'b0;
   logic [N-1:0] i_load_data = '0;
   logic         o_busy, o_done, o_scan_en, o_scan_in, o_verify_err;
   logic [N-1:0] o_capture_data;
   logic         i_scan_out;

   logic [N-1:0] chain;
   logic         pre_load = 1'b0;
   logic [N-1:0] pre_val = '0;
   logic [N-1:0] stuck_mask = '0;

   int n_cmp = 0;
   int n_err = 0;

   tt_scan_ctrl #(.CHAIN_LEN(N)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_load_data(i_load_data),
      .o_busy(o_busy), .o_done(o_done), .o_capture_data(o_capture_data),
      .o_scan_en(o_scan_en), .o_scan_in(o_scan_in), .i_scan_out(i_scan_out),
      .o_verify_err(o_verify_err)
   );

   always #5 i_clk = ~i_clk;

   // Target chain: position 0 nearest scan_in, position N-1 drives scan_out; stuck_mask bits read as 0
   always @(posedge i_clk) begin
      if (pre_load) chain <= pre_val & ~stuck_mask;
      else if (o_scan_en) chain <= {chain[N-2:0], o_scan_in} & ~stuck_mask;
   end
   assign i_scan_out = chain[N-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [N-1:0] v);
      pre_load = 1'b1;
      pre_val  = v;
      @(negedge i_clk);
      pre_load = 1'b0;
   endtask

   // Entered and left just after a negedge with the DUT idle.
   task automatic burst(input logic [N-1:0] load, input logic [N-1:0] late_load, input bit change_late);
      logic [N-1:0] exp_cap, exp_chain, seq;
      logic         exp_err;
      int           en_cnt, done_cyc;
      bit           busy_ok;
      exp_cap   = chain;
      exp_chain = load & ~stuck_mask;
`ifdef TT_SCAN_CTRL_VERIFY_EN
      exp_err = ((load & ~stuck_mask) != load);
`else
      exp_err = 1'b0;
`endif
      i_start = 1'b1;
      i_load_data = load;
      en_cnt = 0; done_cyc = 0; seq = '0; busy_ok = 1'b1;
      for (int cyc = 2; cyc <= LAT + 8; cyc++) begin
         @(negedge i_clk);
         i_start = 1'b0;
         if (change_late && cyc == 2) i_load_data = late_load;
         if (o_scan_en === 1'b1) begin
            if (en_cnt < N) seq = {seq[N-2:0], o_scan_in};
            en_cnt++;
         end
         if (o_busy !== 1'b1) busy_ok = 1'b0;
         if (o_done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
      end
      check("done_latency", done_cyc, LAT);
      check("scan_en_cycles", en_cnt, PASSES * N);
      check("scan_in_seq", seq, load);
      check("busy_during", busy_ok, 1);
      check("capture", o_capture_data, exp_cap);
      check("chain_after", chain, exp_chain);
      check("verify_err", o_verify_err, exp_err);
      $display("burst load=%b capture=%b chain=%b done_cyc=%0d verr=%b",
               load, o_capture_data, chain, done_cyc, o_verify_err);
      @(negedge i_clk);
      check("done_pulse_end", o_done, 0);
      check("busy_end", o_busy, 0);
      check("verify_err_hold", o_verify_err, exp_err);
   endtask

   initial begin
      logic [N-1:0] v;
      int run, gap, runs, exp_runs, wait_cnt;
      bit prev_en, seen_first, done_seen;

      // Reset
      repeat (3) @(negedge i_clk);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_scan_en", o_scan_en, 0);
      check("rst_scan_in", o_scan_in, 0);
      check("rst_capture", o_capture_data, 0);
      check("rst_verify_err", o_verify_err, 0);
      i_rst = 1'b0;
      @(negedge i_clk);

      // Basic load of 0110 over a chain holding 1010
      preload(4'b1010);
      burst(4'b0110, '0, 1'b0);
      check("basic_capture", o_capture_data, 4'b1010);

      // Start held high for 20 cycles
      v = N'($urandom);
      i_load_data = v;
      i_start = 1'b1;
      run = 0; gap = 0; runs = 0; prev_en = 1'b0; seen_first = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge i_clk);
         if (o_scan_en === 1'b1) begin
            if (!prev_en && seen_first) check("held_gap", gap, 2);
            run++;
            gap = 0;
         end else begin
            if (prev_en) begin
               check("held_run_len", run, PASSES * N);
               runs++;
               run = 0;
               seen_first = 1'b1;
            end
            gap++;
         end
         prev_en = o_scan_en;
      end
      exp_runs = 0;
      for (int k = 1; (k - 1) * (PASSES * N + 2) + PASSES * N + 1 <= 20; k++) exp_runs = k;
      check("held_runs", runs, exp_runs);
      i_start = 1'b0;
      wait_cnt = 0;
      while (o_busy === 1'b1 && wait_cnt < 40) begin
         @(negedge i_clk);
         wait_cnt++;
      end
      check("held_drain", o_busy, 0);
      check("held_chain", chain, v);
      $display("held start load=%b runs=%0d chain=%b", v, runs, chain);

      // Reset during SHIFT at k=2
      i_start = 1'b1;
      i_load_data = N'($urandom);
      @(negedge i_clk);
      i_start = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      check("mid_k2_scan_en", o_scan_en, 1);
      i_rst = 1'b1;
      @(negedge i_clk);
      check("mid_rst_scan_en", o_scan_en, 0);
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_done", o_done, 0);
      i_rst = 1'b0;
      done_seen = 1'b0;
      repeat (6) begin
         @(negedge i_clk);
         if (o_done === 1'b1) done_seen = 1'b1;
      end
      check("mid_rst_no_done", done_seen, 0);
      $display("reset mid-shift chain=%b", chain);
      burst(4'b1111, '0, 1'b0);

      // Load data changed right after the start cycle
      burst(4'b0001, 4'b1000, 1'b1);

      // Alternating patterns back to back
      burst(4'b0101, '0, 1'b0);
      burst(4'b1010, '0, 1'b0);
      check("alt_capture", o_capture_data, 4'b0101);

      // Random patterns
      repeat (6) burst(N'($urandom), '0, 1'b0);

`ifdef TT_SCAN_CTRL_VERIFY_EN
      stuck_mask = 4'b0100;
      preload('0);
      burst(4'b0100, '0, 1'b0);
      stuck_mask = '0;
      burst(4'b0100, '0, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
